mod_exp_engine: RTL and testbench
=================================

// Module: mod_exp_engine
// PURPOSE
//  Parametrised modular exponentiation unit for the CRT datapath. Computes
//  a^e mod m (MODE_EXP) or the Fermat inverse a^(m-2) mod m (MODE_INV, m prime)
//  by MSB-first square-and-multiply. Start/done handshake, operand capture,
//  error flagging and an optional constant-time schedule.
// PARAMETERS
//  WIDTH       32  bit width of a, e, m, result; products held in 2*WIDTH bits
//  CONST_TIME  1   1: MULT state runs for every exponent bit; 0: skipped when bit=0
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only in IDLE
//  mode     in   1      0 = a^e mod m, 1 = a^(m-2) mod m (e ignored)
//  a        in   WIDTH  base; any value, reduced mod m internally
//  e        in   WIDTH  exponent (mode 0 only)
//  m        in   WIDTH  modulus
//  busy     out  1      high from the cycle after start is accepted until done
//  done     out  1      one-cycle pulse; result/error valid in that cycle and held
//  result   out  WIDTH  a^e mod m; 0 on error
//  error    out  1      m<2, or mode 1 with a mod m == 0; valid with done
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (reset_n). On reset_n=0:
//   state=IDLE, busy=0, done=0, error=0, result=0; internal p=1, regs cleared.
//   Reset mid-operation aborts immediately; no done pulse follows.
//  IDLE: start=1 -> capture a,m, exponent e_r = mode ? m-2 : e; busy<=1 -> LOAD.
//   start while busy is ignored; inputs may change freely after capture.
//  LOAD: if m<2 -> err<=1 -> FINISH. a_r <= a % m; if mode=1 and a_r==0 ->
//   err<=1 -> FINISH. Else p<=1, idx<=WIDTH-1 -> SQUARE.
//  SQUARE: p <= (p*p) % m (2*WIDTH-bit product).
//   CONST_TIME=1 -> MULT. CONST_TIME=0: e_r[idx]=1 -> MULT, else as MULT exit.
//  MULT: if e_r[idx]: p <= (p*a_r) % m; else p held (CONST_TIME=1 dummy slot).
//   idx==0 -> FINISH; else idx<=idx-1 -> SQUARE.
//  FINISH: result <= err ? 0 : p; error <= err; done<=1 (one cycle); busy<=0
//   -> IDLE. Next start accepted in the cycle done is high (pulse returns 0).
//  Latency (edges from start sample to done high): CONST_TIME=1: 2*WIDTH+2,
//   fixed. CONST_TIME=0: WIDTH+popcount(e_r)+2. Error path: 2.
//  Arithmetic: all intermediates < m after each state; result always < m.
//   e=0 (mode 0, m>=2) -> result 1. a>=m handled by LOAD reduction.
//  result/error hold last value until next FINISH; done is never high with busy.
// TESTING (WIDTH=8)
//  T1 mode0 a=3 e=5 m=7 -> result=5, error=0; CONST_TIME=1 done exactly 18 edges
//     after start; CONST_TIME=0 (popcount 2) done 12 edges after start.
//  T2 mode1 a=10 m=13 -> result=4 (10*4 mod 13 = 1), error=0.
//  T3 mode0 a=20 e=5 m=7 -> result=6; mode0 a=9 e=0 m=11 -> result=1.
//  T4 m=1 (either mode) -> done 2 edges after start, error=1, result=0;
//     mode1 a=14 m=7 -> error=1, result=0.
//  T5 start pulsed again while busy with different operands -> ignored; first
//     result returned; back-to-back start on done cycle accepted.
//  T6 reset_n low mid-SQUARE -> busy/done/result/error=0 asynchronously; no
//     done pulse; fresh start afterwards returns correct result.

Source files
------------

// File: rtl/mod_exp_engine.sv
// mod_exp_engine
//   Modular exponentiation unit for the CRT datapath. It computes either
//   a^e mod m or the Fermat inverse a^(m-2) mod m. The exponent is scanned
//   MSB first using square-and-multiply. Every intermediate value is reduced
//   mod m and held in a 2*WIDTH-bit product.
//
// Parameters
//   WIDTH       operand/result width
//   CONST_TIME  1: the MULT slot runs for every exponent bit (fixed latency)
//               0: the MULT slot is skipped for zero exponent bits
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous, active-low reset
//   start    operation request, sampled only while idle
//   mode     0: a^e mod m, 1: a^(m-2) mod m (e ignored)
//   a, e, m  base, exponent, modulus (captured on start)
//   busy     high from the cycle after start is accepted until done
//   done     one-cycle completion pulse
//   result   a^e mod m, 0 on error; held until the next completion
//   error    m < 2, or mode 1 with a mod m == 0; held with result
module mod_exp_engine #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          CONST_TIME = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error
);

  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQUARE,
    MULT,
    FINISH
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   e_r;
  logic [WIDTH-1:0]   m_r;
  logic               mode_r;
  logic [WIDTH-1:0]   p;
  logic [IDXW-1:0]    idx;
  logic               err;

  logic               m_small;
  logic [WIDTH-1:0]   m_div;
  logic [WIDTH-1:0]   a_red;
  logic               e_bit;
  logic               idx_last;
  logic [WIDTH-1:0]   mul_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   p_next;

  // One shared multiplier/reducer. SQUARE uses p*p and MULT uses p*a_r.
  // The divisor is forced to 1 for m < 2 so that the reduction never divides
  // by zero; that path always ends in an error result.
  always_comb begin
    m_small  = (m_r < WIDTH'(2));
    m_div    = m_small ? WIDTH'(1) : m_r;
    a_red    = a_r % m_div;
    e_bit    = e_r[idx];
    idx_last = (idx == '0);
    mul_b    = (state == MULT) ? a_r : p;
    prod     = {{WIDTH{1'b0}}, p} * {{WIDTH{1'b0}}, mul_b};
    p_next   = WIDTH'(prod % {{WIDTH{1'b0}}, m_div});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (start) next_state = LOAD;
      LOAD: begin
        if (m_small || (mode_r && (a_red == '0))) next_state = FINISH;
        else                                       next_state = SQUARE;
      end
      SQUARE: begin
        if (CONST_TIME || e_bit) next_state = MULT;
        else if (idx_last)       next_state = FINISH;
        else                     next_state = SQUARE;
      end
      MULT:   next_state = idx_last ? FINISH : SQUARE;
      FINISH: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r    <= '0;
      e_r    <= '0;
      m_r    <= '0;
      mode_r <= 1'b0;
      p      <= WIDTH'(1);
      idx    <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r    <= a;
            m_r    <= m;
            mode_r <= mode;
            e_r    <= mode ? (m - WIDTH'(2)) : e;
            err    <= 1'b0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          if (m_small) begin
            err <= 1'b1;
          end else begin
            a_r <= a_red;
            if (mode_r && (a_red == '0)) begin
              err <= 1'b1;
            end else begin
              p   <= WIDTH'(1);
              idx <= IDXW'(WIDTH - 1);
            end
          end
        end
        SQUARE: begin
          p <= p_next;
          // With the variable schedule, a zero bit leaves from SQUARE, so
          // the bit index has to advance here instead of in MULT.
          if (!CONST_TIME && !e_bit && !idx_last) idx <= idx - IDXW'(1);
        end
        MULT: begin
          if (e_bit)     p   <= p_next;
          if (!idx_last) idx <= idx - IDXW'(1);
        end
        FINISH: begin
          result <= err ? '0 : p;
          error  <= err;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
module tb_mod_exp_engine;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start1 = 1'b0, start0 = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0, e = '0, m = '0;
  logic         busy1, done1, error1, busy0, done0, error0;
  logic [W-1:0] result1, result0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  exp_t q1[$];
  exp_t q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_exp_engine #(.WIDTH(W), .CONST_TIME(1'b1)) dut_ct (
    .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode),
    .a(a), .e(e), .m(m), .busy(busy1), .done(done1),
    .result(result1), .error(error1));

  mod_exp_engine #(.WIDTH(W), .CONST_TIME(1'b0)) dut_vt (
    .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode),
    .a(a), .e(e), .m(m), .busy(busy0), .done(done0),
    .result(result0), .error(error0));

  // Reference: right-to-left binary exponentiation on plain integers.
  task automatic model(input bit md, input logic [W-1:0] aa, ee, mm,
                       output logic [W-1:0] r, output bit er,
                       output int l1, output int l0);
    longint unsigned base, acc;
    logic [W-1:0] ex;
    r = '0; er = 1'b0; l1 = 2; l0 = 2;
    ex = md ? W'((int'(mm) + 256 - 2) % 256) : ee;
    if (mm < 2) begin er = 1'b1; return; end
    base = longint'(aa) % longint'(mm);
    if (md && base == 0) begin er = 1'b1; return; end
    acc = 1;
    for (int k = 0; k < W; k++) begin
      if (ex[k]) acc = (acc * base) % longint'(mm);
      base = (base * base) % longint'(mm);
    end
    r  = W'(acc);
    l1 = 2 * W + 2;
    l0 = W + $countones(ex) + 2;
  endtask

  // Called at a negedge; starts the selected engines and queues expectations.
  task automatic issue(input bit s1, s0, md, input logic [W-1:0] aa, ee, mm,
                       input logic [W-1:0] r, input bit er, input int l1, l0);
    exp_t x;
    mode = md; a = aa; e = ee; m = mm;
    start1 = s1; start0 = s0;
    x.res = r; x.err = er; x.t0 = cyc;
    if (s1) begin x.lat = l1; q1.push_back(x); end
    if (s0) begin x.lat = l0; q0.push_back(x); end
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    a = W'($urandom); e = W'($urandom); m = W'($urandom); mode = 1'($urandom);
  endtask

  task automatic issue_model(input bit s1, s0, md, input logic [W-1:0] aa, ee, mm);
    logic [W-1:0] r; bit er; int l1, l0;
    model(md, aa, ee, mm, r, er, l1, l0);
    issue(s1, s0, md, aa, ee, mm, r, er, l1, l0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < budget) begin
      @(negedge clk); n++;
    end
    if (q1.size() != 0 || q0.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: pending ct=%0d vt=%0d after %0d cycles, required 0",
               q1.size(), q0.size(), budget);
      q1.delete(); q0.delete();
    end
  endtask

  // Monitors: compare every done pulse against the queued expectation.
  always @(negedge clk) begin
    if (done1) begin
      exp_t x;
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL ct_unexpected_done: got result=%0d error=%0d, required no done", result1, error1);
      end else begin
        x = q1.pop_front();
        if (result1 !== x.res || error1 !== x.err || (cyc - x.t0 - 1) != x.lat || busy1 !== 1'b0) begin
          fails++;
          $display("FAIL ct_result: got res=%0d err=%0d lat=%0d busy=%0d, required res=%0d err=%0d lat=%0d busy=0",
                   result1, error1, cyc - x.t0 - 1, busy1, x.res, x.err, x.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done0) begin
      exp_t x;
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL vt_unexpected_done: got result=%0d error=%0d, required no done", result0, error0);
      end else begin
        x = q0.pop_front();
        if (result0 !== x.res || error0 !== x.err || (cyc - x.t0 - 1) != x.lat || busy0 !== 1'b0) begin
          fails++;
          $display("FAIL vt_result: got res=%0d err=%0d lat=%0d busy=%0d, required res=%0d err=%0d lat=%0d busy=0",
                   result0, error0, cyc - x.t0 - 1, busy0, x.res, x.err, x.lat);
        end
      end
    end
  end

  task automatic check_idle_zero(input string name);
    tests++;
    if ({busy1, done1, error1, result1, busy0, done0, error0, result0} !== '0) begin
      fails++;
      $display("FAIL %s: got ct busy=%0d done=%0d err=%0d res=%0d vt busy=%0d done=%0d err=%0d res=%0d, required all 0",
               name, busy1, done1, error1, result1, busy0, done0, error0, result0);
    end
  endtask

  task automatic wait_done1(input int budget);
    int n = 0;
    while (!done1 && n < budget) begin @(negedge clk); n++; end
    if (!done1) begin
      tests++; fails++;
      $display("FAIL wait_done_ct: no done within %0d cycles, required done", budget);
    end
  endtask

  task automatic wait_done0(input int budget);
    int n = 0;
    while (!done0 && n < budget) begin @(negedge clk); n++; end
    if (!done0) begin
      tests++; fails++;
      $display("FAIL wait_done_vt: no done within %0d cycles, required done", budget);
    end
  endtask

  initial begin
    logic [W-1:0] primes [10];
    primes = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd97, 8'd241, 8'd251};

    repeat (2) @(negedge clk);
    check_idle_zero("reset_state");
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-derived expectations.
    issue(1, 1, 0, 8'd3,  8'd5, 8'd7,  8'd5, 0, 18, 12); drain(60);
    issue(1, 1, 1, 8'd10, 8'd0, 8'd13, 8'd4, 0, 18, 13); drain(60);
    issue(1, 1, 0, 8'd20, 8'd5, 8'd7,  8'd6, 0, 18, 12); drain(60);
    issue(1, 1, 0, 8'd9,  8'd0, 8'd11, 8'd1, 0, 18, 10); drain(60);
    issue(1, 1, 0, 8'd4,  8'd3, 8'd1,  8'd0, 1, 2, 2);   drain(60);
    issue(1, 1, 1, 8'd4,  8'd3, 8'd1,  8'd0, 1, 2, 2);   drain(60);
    issue(1, 1, 1, 8'd14, 8'd0, 8'd7,  8'd0, 1, 2, 2);   drain(60);
    issue(1, 1, 0, 8'd5,  8'd3, 8'd0,  8'd0, 1, 2, 2);   drain(60);

    // Start while busy, with different operands, must be ignored.
    issue(1, 1, 0, 8'd3, 8'd5, 8'd7, 8'd5, 0, 18, 12);
    repeat (2) @(negedge clk);
    mode = 1'b1; a = 8'd10; e = 8'd77; m = 8'd13;
    start1 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    drain(60);

    // Back-to-back: new start in the cycle done is high.
    issue(1, 0, 0, 8'd3, 8'd5, 8'd7, 8'd5, 0, 18, 12);
    wait_done1(40);
    issue(1, 0, 1, 8'd10, 8'd0, 8'd13, 8'd4, 0, 18, 13);
    drain(60);
    issue(0, 1, 0, 8'd20, 8'd5, 8'd7, 8'd6, 0, 18, 12);
    wait_done0(40);
    issue(0, 1, 0, 8'd9, 8'd0, 8'd11, 8'd1, 0, 18, 10);
    drain(60);

    // Reset in the middle of an operation: immediate clear, no done later.
    issue(1, 1, 0, 8'd3, 8'd5, 8'd7, 8'd5, 0, 18, 12);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_idle_zero("async_reset_midop");
    q1.delete(); q0.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(1, 1, 0, 8'd3, 8'd5, 8'd7, 8'd5, 0, 18, 12); drain(60);

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      bit md;
      logic [W-1:0] mm;
      int sel;
      md  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)  mm = W'($urandom_range(0, 1));
      else if (md)   mm = primes[$urandom_range(0, 9)];
      else           mm = W'($urandom_range(2, 255));
      issue_model(1, 1, md, W'($urandom), W'($urandom), mm);
      drain(60);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
